hazard_ctrl: RTL and testbench

Pipeline hazard controller for the RV32I core. It drives the `stall` and `jmp` inputs of the decode stage. It keeps a shift-register scoreboard of in-flight destination registers for the EX, MEM and WB stages. It interlocks on read-after-write hazards, sequences a multi-cycle flush after a taken branch or jump, and, when forwarding is compiled in, produces bypass selects for the two operands.

---
 rtl/hazard_ctrl_pkg.sv | 43 ++++
 rtl/hazard_sb_slot.sv | 29 ++
 rtl/hazard_ctrl.sv | 142 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// rtl/hazard_ctrl_pkg.sv - RV32I decode function codes, hazard FSM states and load classifier
// Shared by hazard_ctrl, hazard_sb_slot and the bench.
package hazard_ctrl_pkg;

   localparam logic [5:0] F_NOP  = 6'd0;
   localparam logic [5:0] F_ADD  = 6'd1;
   localparam logic [5:0] F_SUB  = 6'd2;
   localparam logic [5:0] F_AND  = 6'd3;
   localparam logic [5:0] F_OR   = 6'd4;
   localparam logic [5:0] F_XOR  = 6'd5;
   localparam logic [5:0] F_SLL  = 6'd6;
   localparam logic [5:0] F_SRL  = 6'd7;
   localparam logic [5:0] F_SRA  = 6'd8;
   localparam logic [5:0] F_SLT  = 6'd9;
   localparam logic [5:0] F_SLTU = 6'd10;
   localparam logic [5:0] F_ADDI = 6'd11;
   localparam logic [5:0] F_LUI  = 6'd12;
   localparam logic [5:0] F_AUIPC = 6'd13;
   localparam logic [5:0] F_LB   = 6'd16;
   localparam logic [5:0] F_LH   = 6'd17;
   localparam logic [5:0] F_LW   = 6'd18;
   localparam logic [5:0] F_LBU  = 6'd19;
   localparam logic [5:0] F_LHU  = 6'd20;
   localparam logic [5:0] F_SB   = 6'd21;
   localparam logic [5:0] F_SH   = 6'd22;
   localparam logic [5:0] F_SW   = 6'd23;
   localparam logic [5:0] F_JAL  = 6'd24;
   localparam logic [5:0] F_JALR = 6'd25;
   localparam logic [5:0] F_BEQ  = 6'd26;
   localparam logic [5:0] F_BNE  = 6'd27;

   localparam logic [1:0] FWD_RF = 2'd0;

   typedef enum logic {
      HZ_RUN   = 1'b0,
      HZ_FLUSH = 1'b1
   } hz_state_t;

   function automatic logic is_load(input logic [5:0] f);
      return (f == F_LB) || (f == F_LH) || (f == F_LW) || (f == F_LBU) || (f == F_LHU);
   endfunction

endpackage

// File: rtl/hazard_sb_slot.sv
// rtl/hazard_sb_slot.sv - one scoreboard entry {valid, rd, is_load} with enable and bubble insert
module hazard_sb_slot
   import hazard_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       bubble,
   input  logic       d_valid,
   input  logic [4:0] d_rd,
   input  logic       d_load,
   output logic       q_valid,
   output logic [4:0] q_rd,
   output logic       q_load
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         q_valid <= 1'b0;
         q_rd    <= 5'd0;
         q_load  <= 1'b0;
      end else if (en) begin
         q_valid <= d_valid & ~bubble;
         q_rd    <= d_rd;
         q_load  <= d_load & ~bubble;
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - RV32I pipeline hazard controller: RAW interlock, redirect flush, bypass selects
// Optional feature macro: HAZARD_FWD_EN (load-use-only interlock plus fwd_a/fwd_b bypass selects).
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int DEPTH        = 3,
   parameter int FLUSH_CYCLES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [4:0] rs1,
   input  logic [4:0] rs2,
   input  logic       rs1v,
   input  logic       rs2v,
   input  logic [4:0] rd,
   input  logic       rdv,
   input  logic [5:0] func,
   input  logic       jmp_req,
   input  logic       ext_stall,
   output logic       stall,
   output logic       jmp,
   output logic [1:0] fwd_a,
   output logic [1:0] fwd_b
);

   localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES - 1);

   hz_state_t  state, state_nxt;
   logic [1:0] cnt, cnt_nxt;

   logic [DEPTH:1] slot_valid, slot_load;
   logic [DEPTH:1] in_valid, in_load, slot_bubble;
   logic [DEPTH:1] match_a, match_b;
   logic [4:0]     slot_rd [1:DEPTH];
   logic [4:0]     in_rd   [1:DEPTH];

   logic advance, kill, hazard, dec_load;

   assign advance = ~ext_stall;

`ifdef HAZARD_FWD_EN
   logic unused_tail;
   assign dec_load    = is_load(func);
   assign unused_tail = slot_load[DEPTH];
`else
   logic unused_cfg;
   assign dec_load   = 1'b0;
   assign unused_cfg = ^{func, slot_load};
`endif

   // Slot 1 is fed from decode; each later slot is fed by its predecessor.
   for (genvar g = 1; g <= DEPTH; g++) begin : g_slot
      if (g == 1) begin : g_head
         assign in_valid[g]    = rdv;
         assign in_rd[g]       = rd;
         assign in_load[g]     = dec_load;
         assign slot_bubble[g] = kill;
      end else begin : g_tail
         assign in_valid[g]    = slot_valid[g-1];
         assign in_rd[g]       = slot_rd[g-1];
         assign in_load[g]     = slot_load[g-1];
         assign slot_bubble[g] = 1'b0;
      end

      hazard_sb_slot u_slot (
         .clk     (clk),
         .rst     (rst),
         .en      (advance),
         .bubble  (slot_bubble[g]),
         .d_valid (in_valid[g]),
         .d_rd    (in_rd[g]),
         .d_load  (in_load[g]),
         .q_valid (slot_valid[g]),
         .q_rd    (slot_rd[g]),
         .q_load  (slot_load[g])
      );

      assign match_a[g] = slot_valid[g] & rs1v & (rs1 == slot_rd[g]) & (rs1 != 5'd0);
      assign match_b[g] = slot_valid[g] & rs2v & (rs2 == slot_rd[g]) & (rs2 != 5'd0);
   end

`ifdef HAZARD_FWD_EN
   assign hazard = (match_a[1] | match_b[1]) & slot_load[1];
`else
   assign hazard = |{match_a, match_b};
`endif

   // Youngest producer wins: scan oldest to youngest so the lowest slot overrides.
   always_comb begin
      fwd_a = FWD_RF;
      fwd_b = FWD_RF;
`ifdef HAZARD_FWD_EN
      for (int k = DEPTH; k >= 1; k--) begin
         if (match_a[k]) fwd_a = 2'(k);
         if (match_b[k]) fwd_b = 2'(k);
      end
`endif
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= HZ_RUN;
         cnt   <= 2'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      jmp       = jmp_req | (state == HZ_FLUSH);
      stall     = ext_stall | (hazard & ~jmp);
      kill      = stall | jmp;
      if (!ext_stall) begin
         unique case (state)
            HZ_RUN: begin
               if (jmp_req && (FLUSH_CYCLES > 1)) begin
                  state_nxt = HZ_FLUSH;
                  cnt_nxt   = FLUSH_LOAD;
               end
            end
            HZ_FLUSH: begin
               if (jmp_req) begin
                  cnt_nxt = FLUSH_LOAD;
               end else if (cnt <= 2'd1) begin
                  state_nxt = HZ_RUN;
                  cnt_nxt   = 2'd0;
               end else begin
                  cnt_nxt = cnt - 2'd1;
               end
            end
            default: begin
               state_nxt = HZ_RUN;
               cnt_nxt   = 2'd0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed self-checking bench for hazard_ctrl (DEPTH=3, FLUSH_CYCLES=2)
// Expectations follow HAZARD_FWD_EN when the bench is built with it.
module tb_hazard_ctrl;
   import hazard_ctrl_pkg::*;

`ifdef HAZARD_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] rs1, rs2, rd;
   logic       rs1v, rs2v, rdv;
   logic [5:0] func;
   logic       jmp_req, ext_stall;
   logic       stall, jmp;
   logic [1:0] fwd_a, fwd_b;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   hazard_ctrl #(.DEPTH(3), .FLUSH_CYCLES(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .rs1       (rs1),
      .rs2       (rs2),
      .rs1v      (rs1v),
      .rs2v      (rs2v),
      .rd        (rd),
      .rdv       (rdv),
      .func      (func),
      .jmp_req   (jmp_req),
      .ext_stall (ext_stall),
      .stall     (stall),
      .jmp       (jmp),
      .fwd_a     (fwd_a),
      .fwd_b     (fwd_b)
   );

   task automatic set_in(input logic [4:0] a, input logic av, input logic [4:0] b, input logic bv,
                         input logic [4:0] d, input logic dv, input logic [5:0] f,
                         input logic jr, input logic es);
      rs1 = a; rs1v = av; rs2 = b; rs2v = bv;
      rd = d; rdv = dv; func = f; jmp_req = jr; ext_stall = es;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic settle;
      #3;
   endtask

   task automatic drain;
      set_in(0, 0, 0, 0, 0, 0, F_NOP, 0, 0);
      repeat (3) tick();
   endtask

   task automatic test_reset;
      rst = 1'b0;
      set_in(0, 0, 0, 0, 0, 0, F_NOP, 1, 1);
      #2;
      checks++;
      if ({stall, jmp, fwd_a, fwd_b} !== 6'b11_00_00) begin
         errors++;
         $display("FAIL reset_pass: {stall,jmp,fwd_a,fwd_b}=%b expected 110000", {stall, jmp, fwd_a, fwd_b});
      end
      set_in(0, 0, 0, 0, 0, 0, F_NOP, 0, 0);
      #2;
      checks++;
      if ({stall, jmp, fwd_a, fwd_b} !== 6'b00_00_00) begin
         errors++;
         $display("FAIL reset_idle: {stall,jmp,fwd_a,fwd_b}=%b expected 000000", {stall, jmp, fwd_a, fwd_b});
      end
      tick();
      rst = 1'b1;
      tick();
   endtask

   task automatic test_raw;
      logic       es;
      logic [1:0] ef;
      drain();
      set_in(1, 1, 0, 0, 5, 1, F_ADDI, 0, 0);
      settle();
      checks++;
      if (stall !== 1'b0) begin
         errors++;
         $display("FAIL raw_producer: stall=%b expected 0", stall);
      end
      tick();
      set_in(5, 1, 1, 1, 6, 1, F_ADD, 0, 0);
      for (int c = 0; c < 4; c++) begin
         settle();
         es = FWD ? 1'b0 : (c < 3);
         ef = (FWD && c < 3) ? 2'(c + 1) : 2'd0;
         checks++;
         if ({stall, fwd_a, fwd_b} !== {es, ef, 2'd0}) begin
            errors++;
            $display("FAIL raw_dep c%0d: stall=%b fwd_a=%0d fwd_b=%0d expected stall=%b fwd_a=%0d fwd_b=0",
                     c, stall, fwd_a, fwd_b, es, ef);
         end
         tick();
      end
   endtask

   task automatic test_load_use;
      logic       es;
      logic [1:0] ef;
      drain();
      set_in(2, 1, 0, 0, 7, 1, F_LW, 0, 0);
      tick();
      set_in(7, 1, 7, 1, 8, 1, F_ADD, 0, 0);
      for (int c = 0; c < 4; c++) begin
         settle();
         es = FWD ? (c == 0) : (c < 3);
         ef = (FWD && c < 3) ? 2'(c + 1) : 2'd0;
         checks++;
         if ({stall, fwd_a, fwd_b} !== {es, ef, ef}) begin
            errors++;
            $display("FAIL load_use c%0d: stall=%b fwd_a=%0d fwd_b=%0d expected stall=%b fwd_a=fwd_b=%0d",
                     c, stall, fwd_a, fwd_b, es, ef);
         end
         tick();
      end
   endtask

   task automatic test_x0_and_valid;
      drain();
      set_in(0, 0, 0, 0, 0, 1, F_LW, 0, 0);
      tick();
      set_in(0, 1, 0, 1, 3, 1, F_ADD, 0, 0);
      settle();
      checks++;
      if ({stall, fwd_a, fwd_b} !== 5'b0_00_00) begin
         errors++;
         $display("FAIL x0_source: stall=%b fwd_a=%0d fwd_b=%0d expected all 0", stall, fwd_a, fwd_b);
      end
      drain();
      set_in(0, 0, 0, 0, 9, 1, F_LW, 0, 0);
      tick();
      set_in(9, 0, 9, 0, 0, 0, F_NOP, 0, 0);
      settle();
      checks++;
      if ({stall, fwd_a, fwd_b} !== 5'b0_00_00) begin
         errors++;
         $display("FAIL src_invalid: stall=%b fwd_a=%0d fwd_b=%0d expected all 0", stall, fwd_a, fwd_b);
      end
      set_in(9, 1, 9, 0, 0, 0, F_NOP, 0, 0);
      settle();
      checks++;
      if ({stall, fwd_a, fwd_b} !== {1'b1, (FWD ? 2'd1 : 2'd0), 2'd0}) begin
         errors++;
         $display("FAIL src_valid: stall=%b fwd_a=%0d fwd_b=%0d expected stall=1 fwd_a=%0d fwd_b=0",
                  stall, fwd_a, fwd_b, FWD ? 1 : 0);
      end
   endtask

   task automatic test_flush;
      drain();
      set_in(0, 0, 0, 0, 10, 1, F_ADDI, 1, 0);
      settle();
      checks++;
      if ({jmp, stall} !== 2'b10) begin
         errors++;
         $display("FAIL flush_c0: jmp=%b stall=%b expected jmp=1 stall=0", jmp, stall);
      end
      tick();
      set_in(0, 0, 0, 0, 11, 1, F_ADDI, 0, 0);
      settle();
      checks++;
      if ({jmp, stall} !== 2'b10) begin
         errors++;
         $display("FAIL flush_c1: jmp=%b stall=%b expected jmp=1 stall=0", jmp, stall);
      end
      tick();
      set_in(10, 1, 11, 1, 0, 0, F_NOP, 0, 0);
      settle();
      checks++;
      if ({jmp, stall, fwd_a, fwd_b} !== 6'b00_00_00) begin
         errors++;
         $display("FAIL flush_bubbles: jmp=%b stall=%b fwd_a=%0d fwd_b=%0d expected all 0",
                  jmp, stall, fwd_a, fwd_b);
      end
      drain();
      for (int c = 0; c < 4; c++) begin
         set_in(0, 0, 0, 0, 0, 0, F_NOP, (c < 2), 0);
         settle();
         checks++;
         if (jmp !== (c < 3)) begin
            errors++;
            $display("FAIL flush_extend c%0d: jmp=%b expected %b", c, jmp, (c < 3));
         end
         tick();
      end
   endtask

   task automatic test_jmp_hazard;
      drain();
      set_in(0, 0, 0, 0, 12, 1, F_LW, 0, 0);
      tick();
      set_in(12, 1, 13, 1, 13, 1, F_ADD, 1, 0);
      settle();
      checks++;
      if ({jmp, stall} !== 2'b10) begin
         errors++;
         $display("FAIL jmp_hazard_c0: jmp=%b stall=%b expected jmp=1 stall=0", jmp, stall);
      end
      tick();
      set_in(12, 1, 13, 1, 13, 1, F_ADD, 0, 0);
      settle();
      checks++;
      if ({jmp, stall} !== 2'b10) begin
         errors++;
         $display("FAIL jmp_hazard_c1: jmp=%b stall=%b expected jmp=1 stall=0", jmp, stall);
      end
      tick();
      settle();
      checks++;
      if ({jmp, stall, fwd_a, fwd_b} !== {1'b0, ~FWD, (FWD ? 2'd3 : 2'd0), 2'd0}) begin
         errors++;
         $display("FAIL jmp_hazard_c2: jmp=%b stall=%b fwd_a=%0d fwd_b=%0d expected jmp=0 stall=%b fwd_a=%0d fwd_b=0",
                  jmp, stall, fwd_a, fwd_b, ~FWD, FWD ? 3 : 0);
      end
   endtask

   task automatic test_ext_stall;
      drain();
      set_in(0, 0, 0, 0, 14, 1, F_ADDI, 0, 0);
      tick();
      set_in(0, 0, 0, 0, 0, 0, F_NOP, 1, 0);
      tick();
      for (int c = 0; c < 4; c++) begin
         set_in(0, 0, 0, 0, 0, 0, F_NOP, 0, 1);
         settle();
         checks++;
         if ({jmp, stall} !== 2'b11) begin
            errors++;
            $display("FAIL ext_stall_hold c%0d: jmp=%b stall=%b expected jmp=1 stall=1", c, jmp, stall);
         end
         tick();
      end
      set_in(0, 0, 0, 0, 0, 0, F_NOP, 0, 0);
      settle();
      checks++;
      if ({jmp, stall} !== 2'b10) begin
         errors++;
         $display("FAIL ext_stall_resume: jmp=%b stall=%b expected jmp=1 stall=0", jmp, stall);
      end
      tick();
      set_in(14, 1, 0, 0, 0, 0, F_NOP, 0, 0);
      settle();
      checks++;
      if ({jmp, stall, fwd_a} !== {1'b0, ~FWD, (FWD ? 2'd3 : 2'd0)}) begin
         errors++;
         $display("FAIL ext_stall_slots: jmp=%b stall=%b fwd_a=%0d expected jmp=0 stall=%b fwd_a=%0d",
                  jmp, stall, fwd_a, ~FWD, FWD ? 3 : 0);
      end
   endtask

   task automatic test_reset_midflush;
      drain();
      set_in(0, 0, 0, 0, 15, 1, F_LW, 0, 0);
      tick();
      set_in(0, 0, 0, 0, 0, 0, F_NOP, 1, 0);
      tick();
      set_in(15, 1, 0, 0, 0, 0, F_NOP, 0, 0);
      settle();
      checks++;
      if (jmp !== 1'b1) begin
         errors++;
         $display("FAIL midflush_pre: jmp=%b expected 1", jmp);
      end
      rst = 1'b0;
      #1;
      checks++;
      if ({jmp, stall, fwd_a, fwd_b} !== 6'b00_00_00) begin
         errors++;
         $display("FAIL midflush_reset: jmp=%b stall=%b fwd_a=%0d fwd_b=%0d expected all 0",
                  jmp, stall, fwd_a, fwd_b);
      end
      tick();
      settle();
      checks++;
      if ({jmp, stall, fwd_a, fwd_b} !== 6'b00_00_00) begin
         errors++;
         $display("FAIL midflush_held: jmp=%b stall=%b fwd_a=%0d fwd_b=%0d expected all 0",
                  jmp, stall, fwd_a, fwd_b);
      end
      rst = 1'b1;
      tick();
      settle();
      checks++;
      if ({jmp, stall, fwd_a, fwd_b} !== 6'b00_00_00) begin
         errors++;
         $display("FAIL midflush_release: jmp=%b stall=%b fwd_a=%0d fwd_b=%0d expected all 0",
                  jmp, stall, fwd_a, fwd_b);
      end
   endtask

   initial begin
      test_reset();
      test_raw();
      test_load_use();
      test_x0_and_valid();
      test_flush();
      test_jmp_hazard();
      test_ext_stall();
      test_reset_midflush();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
